// File: rtl/buffer_ctrl_pkg.sv
// Shared constants for the buffer pool read sequencer: shift-register control
// codes, FSM state encoding, counter widths and the latched command record.
package buffer_ctrl_pkg;

  localparam logic [2:0] CTRL_HOLD    = 3'd0;
  localparam logic [2:0] CTRL_LOAD    = 3'd1;
  localparam logic [2:0] CTRL_SHIFT_A = 3'd2;
  localparam logic [2:0] CTRL_SHIFT_B = 3'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int ROW_W   = 8;
  localparam int SHIFT_W = 4;
  localparam int WAIT_W  = 8;

  typedef struct packed {
    logic [ROW_W-1:0]   rows;
    logic [SHIFT_W-1:0] shifts;
    logic [3:0]         iszero;
    logic [7:0]         buffermux;
  } cmd_cfg_t;

  // Shift phases alternate A,B,A,... with the first shift of every row on A.
  function automatic logic [2:0] shift_phase(input logic odd);
    return odd ? CTRL_SHIFT_B : CTRL_SHIFT_A;
  endfunction

endpackage

// File: rtl/buffer_pool_sequencer_if.sv
// Command channel from the layer scheduler into the buffer pool sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// cmd_ready is high only while the sequencer is idle and there is no queueing.
interface buffer_pool_sequencer_if
  import buffer_ctrl_pkg::*;
#(
  parameter int ADDR_LEN = 9
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_LEN-1:0] cmd_base;
  logic [ROW_W-1:0]    cmd_rows;
  logic [SHIFT_W-1:0]  cmd_shifts;
  logic [3:0]          cmd_iszero;
  logic [7:0]          cmd_buffermux;

  modport master (
    output cmd_valid, cmd_base, cmd_rows, cmd_shifts, cmd_iszero, cmd_buffermux,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_rows, cmd_shifts, cmd_iszero, cmd_buffermux,
    output cmd_ready
  );
endinterface

// File: rtl/buffer_seq_addr_gen.sv
// Row counter and base+row read address, wrapped to ADDR_LEN bits and
// broadcast to every buffer slice. The address register only updates on issue.
module buffer_seq_addr_gen
  import buffer_ctrl_pkg::*;
#(
  parameter int ADDR_LEN   = 9,
  parameter int BUFFER_NUM = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_LEN-1:0]            start_base,
  input  logic                           step,
  input  logic                           issue,
  output logic [ROW_W-1:0]               row,
  output logic [BUFFER_NUM*ADDR_LEN-1:0] addrb
);

  logic [ADDR_LEN-1:0]            base_q, base_d;
  logic [ROW_W-1:0]               row_q, row_d;
  logic [BUFFER_NUM*ADDR_LEN-1:0] addrb_q, addrb_d;
  logic [ADDR_LEN-1:0]            slice;

  // The address is built from next-cycle base/row so it lines up with READ.
  always_comb begin
    base_d = start ? start_base : base_q;
    row_d  = row_q;
    if (start)     row_d = '0;
    else if (step) row_d = row_q + ROW_W'(1);
    slice   = base_d + ADDR_LEN'(row_d);
    addrb_d = issue ? {BUFFER_NUM{slice}} : addrb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      row_q   <= '0;
      addrb_q <= '0;
    end else begin
      base_q  <= base_d;
      row_q   <= row_d;
      addrb_q <= addrb_d;
    end
  end

  assign row   = row_q;
  assign addrb = addrb_q;

endmodule

// File: rtl/buffer_pool_sequencer.sv
// Read-side sequencer for the BufferPool and buffer_shift_register: per row it
// issues a broadcast read, waits READ_LAT, loads, then shifts. Optional
// BUF_SEQ_PERF_EN adds a saturating busy-cycle counter output.
module buffer_pool_sequencer
  import buffer_ctrl_pkg::*;
#(
  parameter int X_MAC    = 4,
  parameter int X_MESH   = 16,
  parameter int ADDR_LEN = 9,
  parameter int READ_LAT = 1,
  localparam int BUFFER_NUM = X_MAC * X_MESH,
  localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  buffer_pool_sequencer_if.slave cmd,
  input  logic                  abort,
  output logic [ADDRWIDTH-1:0]  addrb,
  output logic [2:0]            control,
  output logic [3:0]            iszero,
  output logic [7:0]            buffermux,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
`ifdef BUF_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT - 1);
  localparam logic [ROW_W:0]    ONE_ROW   = (ROW_W+1)'(1);

  logic [2:0]         state_q, state_d;
  cmd_cfg_t           cfg_q, cfg_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [2:0]         control_q, control_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               start, step, issue, last_row;
  logic [ROW_W-1:0]   row;

  always_comb begin
    start       = (state_q == S_IDLE) && cmd.cmd_valid;
    last_row    = ({1'b0, row} + ONE_ROW) >= {1'b0, cfg_q.rows};
    state_d     = state_q;
    cfg_d       = cfg_q;
    wait_cnt_d  = wait_cnt_q;
    shift_cnt_d = shift_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d.rows      = cmd.cmd_rows;
          cfg_d.shifts    = cmd.cmd_shifts;
          cfg_d.iszero    = cmd.cmd_iszero;
          cfg_d.buffermux = cmd.cmd_buffermux;
          state_d = (cmd.cmd_rows == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_LOAD;
        else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      S_LOAD: begin
        shift_cnt_d = '0;
        if (cfg_q.shifts != '0) state_d = S_SHIFT;
        else                    state_d = last_row ? S_DONE : S_READ;
      end
      S_SHIFT: begin
        if (shift_cnt_q == cfg_q.shifts - SHIFT_W'(1)) state_d = last_row ? S_DONE : S_READ;
        else                                           shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over any progress; done is never raised on this path.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

    issue = (state_d == S_READ);
    step  = issue && (state_q != S_IDLE);

    control_d = CTRL_HOLD;
    if (state_d == S_LOAD)       control_d = CTRL_LOAD;
    else if (state_d == S_SHIFT) control_d = shift_phase(shift_cnt_d[0]);

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      wait_cnt_q  <= '0;
      shift_cnt_q <= '0;
      control_q   <= CTRL_HOLD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      wait_cnt_q  <= wait_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      control_q   <= control_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  buffer_seq_addr_gen #(
    .ADDR_LEN  (ADDR_LEN),
    .BUFFER_NUM(BUFFER_NUM)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_base(cmd.cmd_base),
    .step      (step),
    .issue     (issue),
    .row       (row),
    .addrb     (addrb)
  );

  assign cmd.cmd_ready = ready_q;
  assign control       = control_q;
  assign iszero        = cfg_q.iszero;
  assign buffermux     = cfg_q.buffermux;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

`ifdef BUF_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (busy_q && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_busy_cycles = perf_q;
`endif

endmodule

// File: tb/tb_buffer_pool_sequencer.sv
// Bench for buffer_pool_sequencer: a row-level model queues the expected
// per-cycle outputs of each command and they are compared cycle by cycle.
module tb_buffer_pool_sequencer;
  import buffer_ctrl_pkg::*;

  localparam int ADDR_LEN   = 9;
  localparam int BUFFER_NUM = 64;
  localparam int READ_LAT   = 1;
  localparam int AW         = BUFFER_NUM * ADDR_LEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          abort;
  logic [AW-1:0] addrb;
  logic [2:0]    control;
  logic [3:0]    iszero;
  logic [7:0]    buffermux;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;
`ifdef BUF_SEQ_PERF_EN
  logic [31:0]   perf_busy_cycles;
`endif

  buffer_pool_sequencer_if #(.ADDR_LEN(ADDR_LEN)) cmd_if ();

  buffer_pool_sequencer #(
    .X_MAC   (4),
    .X_MESH  (16),
    .ADDR_LEN(ADDR_LEN),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .abort    (abort),
    .addrb    (addrb),
    .control  (control),
    .iszero   (iszero),
    .buffermux(buffermux),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
`ifdef BUF_SEQ_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  // entry: {cmd_ready, busy, done, control[2:0], addr slice[8:0]}
  logic [14:0]         exp_q[$];
  logic [ADDR_LEN-1:0] exp_addr;
  logic [3:0]          exp_iszero;
  logic [7:0]          exp_bmux;
  int                  n_cmp;
  int                  n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pack_exp(input logic rdy, input logic bsy, input logic dn,
                                           input logic [2:0] ctrl, input logic [ADDR_LEN-1:0] a);
    return {rdy, bsy, dn, ctrl, a};
  endfunction

  // Expected trace from the cycle after accept until the sequencer is idle again.
  task automatic model_push(input logic [ADDR_LEN-1:0] base, input int rows, input int shifts,
                            input int abort_at);
    logic [14:0]         tr[$];
    logic [14:0]         dummy;
    logic [ADDR_LEN-1:0] a;
    a = exp_addr;
    if (rows == 0) begin
      tr.push_back(pack_exp(1'b0, 1'b1, 1'b1, CTRL_HOLD, a));
    end else begin
      for (int r = 0; r < rows; r++) begin
        a = base + ADDR_LEN'(r);
        tr.push_back(pack_exp(1'b0, 1'b1, 1'b0, CTRL_HOLD, a));
        for (int w = 0; w < READ_LAT; w++) tr.push_back(pack_exp(1'b0, 1'b1, 1'b0, CTRL_HOLD, a));
        tr.push_back(pack_exp(1'b0, 1'b1, 1'b0, CTRL_LOAD, a));
        for (int s = 0; s < shifts; s++)
          tr.push_back(pack_exp(1'b0, 1'b1, 1'b0, (s % 2 == 1) ? CTRL_SHIFT_B : CTRL_SHIFT_A, a));
      end
      tr.push_back(pack_exp(1'b0, 1'b1, 1'b1, CTRL_HOLD, a));
    end
    if (abort_at > 0) begin
      while (tr.size() > abort_at) dummy = tr.pop_back();
    end
    a = tr[tr.size()-1][ADDR_LEN-1:0];
    tr.push_back(pack_exp(1'b1, 1'b0, 1'b0, CTRL_HOLD, a));
    exp_addr = a;
    foreach (tr[i]) exp_q.push_back(tr[i]);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at the negedge of its first idle cycle.
  task automatic run_cmd(input logic [ADDR_LEN-1:0] base, input int rows, input int shifts,
                         input int abort_at, input logic abort_in_idle);
    logic [3:0]    isz;
    logic [7:0]    bm;
    logic [14:0]   exp_w;
    logic [14:0]   obs_w;
    logic [AW-1:0] full_exp;
    int            n;
    int            loads_exp;
    int            loads_obs;
    isz = 4'($urandom_range(1, 15));
    bm  = 8'($urandom_range(1, 255));
    check_eq("ready_before_cmd", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_base      = base;
    cmd_if.cmd_rows      = 8'(rows);
    cmd_if.cmd_shifts    = 4'(shifts);
    cmd_if.cmd_iszero    = isz;
    cmd_if.cmd_buffermux = bm;
    abort                = abort_in_idle;
    model_push(base, rows, shifts, abort_at);
    exp_iszero = isz;
    exp_bmux   = bm;
    loads_exp  = 0;
    loads_obs  = 0;
    foreach (exp_q[i]) if (exp_q[i][11:9] == CTRL_LOAD) loads_exp++;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      exp_w    = exp_q.pop_front();
      obs_w    = {cmd_if.cmd_ready, busy, done, control, addrb[ADDR_LEN-1:0]};
      full_exp = {BUFFER_NUM{exp_w[ADDR_LEN-1:0]}};
      check_eq($sformatf("cycle%0d_b%0d_r%0d_s%0d", n, base, rows, shifts), obs_w, exp_w);
      check_eq($sformatf("addr_bcast%0d", n), (addrb == full_exp), 1);
      if (control == CTRL_LOAD) loads_obs++;
      if (n == 1) begin
        cmd_if.cmd_valid = 1'b0;
        abort            = 1'b0;
      end
      // A busy-time offer with different fields must be ignored.
      if (n == 2 && abort_at < 0 && rows != 0) begin
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_base      = ADDR_LEN'($urandom);
        cmd_if.cmd_rows      = 8'($urandom_range(1, 9));
        cmd_if.cmd_iszero    = ~isz;
        cmd_if.cmd_buffermux = ~bm;
      end
      if (n == 4) cmd_if.cmd_valid = 1'b0;
      if (n == abort_at) abort = 1'b1;
      if (n == abort_at + 1) abort = 1'b0;
    end
    check_eq("iszero_latched", iszero, exp_iszero);
    check_eq("buffermux_latched", buffermux, exp_bmux);
    if (abort_at < 0) check_eq("load_pulses", loads_obs, loads_exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp                = 0;
    n_err                = 0;
    rst                  = 1'b1;
    abort                = 1'b0;
    exp_addr             = '0;
    cmd_if.cmd_valid     = 1'b0;
    cmd_if.cmd_base      = '0;
    cmd_if.cmd_rows      = '0;
    cmd_if.cmd_shifts    = '0;
    cmd_if.cmd_iszero    = '0;
    cmd_if.cmd_buffermux = '0;
    repeat (2) @(negedge clk);

    check_eq("rst_control", control, 0);
    check_eq("rst_addrb", (addrb == '0), 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ready", cmd_if.cmd_ready, 1);
    check_eq("rst_state", dbg_state, S_IDLE);
`ifdef BUF_SEQ_PERF_EN
    check_eq("rst_perf", perf_busy_cycles, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_cmd(9'd3, 2, 2, -1, 1'b0);      // base/row addressing, done in 11th cycle
`ifdef BUF_SEQ_PERF_EN
    check_eq("perf_after_t1", perf_busy_cycles, 11);
`endif
    run_cmd(9'd511, 2, 1, -1, 1'b0);    // address wrap
    run_cmd(9'd77, 0, 3, -1, 1'b0);     // zero rows
    run_cmd(9'd10, 3, 0, -1, 1'b0);     // load only
    run_cmd(9'd20, 3, 2, 9, 1'b0);      // abort in the second row's first shift
    run_cmd(9'd40, 1, 3, -1, 1'b1);     // accepted right after abort; abort in idle ignored
    repeat (4) run_cmd(ADDR_LEN'($urandom), $urandom_range(0, 3), $urandom_range(0, 5), -1, 1'b0);

    // Asynchronous reset while waiting out the read latency.
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_base      = 9'd5;
    cmd_if.cmd_rows      = 8'd2;
    cmd_if.cmd_shifts    = 4'd1;
    cmd_if.cmd_iszero    = 4'hA;
    cmd_if.cmd_buffermux = 8'h5C;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_state", dbg_state, S_WAIT);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_control", control, 0);
    check_eq("arst_addrb", (addrb == '0), 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_ready", cmd_if.cmd_ready, 1);
    check_eq("arst_iszero", iszero, 0);
    check_eq("arst_buffermux", buffermux, 0);
    check_eq("arst_state", dbg_state, S_IDLE);
`ifdef BUF_SEQ_PERF_EN
    check_eq("arst_perf", perf_busy_cycles, 0);
`endif
    exp_addr = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    run_cmd(9'd3, 2, 2, -1, 1'b0);
`ifdef BUF_SEQ_PERF_EN
    check_eq("perf_after_rst_t1", perf_busy_cycles, 11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
